synch_down_counter: RTL
=======================

# synch_down_counter

Loadable, enable-gated synchronous down counter built as a toggle (T-type) chain running in the decrement direction. It is the countdown counterpart of the team's synchronous up counter and serves as a programmable interval timer. It is preloaded with a count, decrements on enabled clocks, and emits a one-cycle terminal-count pulse on expiry. Downstream blocks use `tc` as a timeout or tick strobe and `busy` as a running flag.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 2–16.
- `clk`  input  1: rising-edge clock.
- `reset_n`  input  1: asynchronous, active-low reset.
- `load`  input  1: synchronous load strobe; sampled on the rising edge of `clk`.
- `load_val`  input  WIDTH: value captured when `load`=1.
- `en`  input  1: count enable; decrements only while in RUN.
- `Q`  output  WIDTH: current count; registered.
- `zero`  output  1: combinational, `Q`==0.
- `tc`  output  1: terminal-count pulse; registered, one cycle wide.
- `busy`  output  1: registered, 1 while in RUN.

## Operation
- **States.** The FSM has two states, IDLE and RUN. `busy` = (state==RUN).
- **Reset values.** Reset forces `Q`=0, `tc`=0, `busy`=0, reload register=0 and state=IDLE. Reset takes effect immediately, without a clock edge. Reset asserted mid-count discards the count and produces no `tc`.
- **Priority per edge.** `load` has priority over `en`.
- **Load from IDLE.**
  - `load_val`≠0: `Q`←`load_val`, go to RUN.
  - `load_val`=0: stay in IDLE, `Q`=0, no `tc`.
- **Load from RUN.** Restart with `Q`←`load_val`; this applies even when `en`=1 or `Q`=1 on the same edge. No `tc` is produced. If `load_val`=0, go to IDLE.
- **Decrement.** Occurs in RUN with `en`=1 and `load`=0.
  - Bit 0 toggles every enabled cycle.
  - Bit i toggles when `en` and `Q[i-1:0]`==0. This is the borrow chain (AND of inverted lower bits).
- **Hold.** With `en`=0 and `load`=0, `Q` and the state are unchanged.
- **Terminal event.** An enabled decrement in RUN with `Q`==1:
  - `tc`←1 for exactly one cycle.
  - Non-reload behaviour: `Q`←0, go to IDLE.
- **IDLE saturation.** In IDLE with `en`=1, `Q` stays at 0. There is no wrap to all-ones and no `tc`.
- **Width rules.** `load_val` is unsigned WIDTH bits. The maximum count is 2^WIDTH−1. `Q` never wraps below 0.

## Timing
- **Load latency.** `Q` shows `load_val` one edge after `load` is sampled.
- **Interval.** After loading N, `tc` is high in the cycle immediately after the N-th enabled edge. `tc` and the final `Q` update on the same edge.
- **`busy` fall.** `busy` falls on the same edge that raises `tc`; non-reload build only.
- **`tc` width.** `tc` is high for 1 cycle regardless of `en` in the following cycle.
- **`zero`.** `zero` follows `Q` combinationally, with no added latency.

## Configuration
- **Macro:** `SYNCH_DOWN_COUNTER_AUTO_RELOAD_EN`.
- **Defined:**
  - An internal WIDTH-bit reload register captures `load_val` on every `load`.
  - On the terminal event, `Q`←reload value, the state stays in RUN and `tc` pulses.
  - `Q` never presents 0 while running.
  - `tc` period = N enabled cycles.
  - A `load` of 0 still returns the block to IDLE.
- **Undefined:** the reload register is absent and the terminal event goes to IDLE with `Q`=0, as in Operation.

## Test plan
1. **Asynchronous reset mid-count.** WIDTH=4, load 5, then assert `reset_n`=0 between edges → `Q`=0, `busy`=0, `tc`=0 immediately; no later `tc`.
2. **Full countdown.** Load 9, `en`=1 held.
   - `Q` runs 9,8,…,1,0 over 9 edges.
   - `tc`=1 for exactly one cycle, coincident with `Q`=0; `busy` drops on the same edge.
   - With further `en`, `Q` stays at 0 and `tc` stays 0.
3. **Enable gating.** Load 3, then `en` pattern 1,0,1,0,1 → `Q` 2,2,1,1,0; a single `tc` on the last edge.
4. **Load collisions.**
   - At `Q`=4, load 12 → `Q`=12, no `tc`.
   - At `Q`=1 with `en`=1, load 0 → `Q`=0, IDLE, no `tc`.
   - Load 0 from IDLE → stays IDLE.
5. **Borrow chain.** Load 15 and count to 0 → observe the 8→7 transition (all bits toggle) and the 1→0 terminal transition; `Q` never reads 15 after the first edge.
6. **Auto-reload build.** With the macro defined, load 3 and hold `en` → `Q` 2,1,3,2,1,3…; `tc` pulses every 3rd enabled edge; `busy` stays 1; `zero` never asserts.

Source files
------------

// File: rtl/synch_down_counter.sv
// synch_down_counter: loadable, enable-gated down counter built as a T-type borrow chain,
// with a one-cycle terminal-count pulse. Define SYNCH_DOWN_COUNTER_AUTO_RELOAD_EN for auto-reload.
module synch_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] next_q;
    logic             next_tc;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] restart_val;

`ifdef SYNCH_DOWN_COUNTER_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;

    logic [WIDTH-1:0] reload;

    // Every load refreshes the reload value, including a load of 0 that parks the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload <= '0;
        end else if (load) begin
            reload <= load_val;
        end
    end

    assign restart_val = reload;
`else
    localparam bit AUTO_RELOAD = 1'b0;

    assign restart_val = '0;
`endif

    // Bit i toggles when every lower bit is 0 (the borrow propagates through them).
    always_comb begin
        toggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = ((Q & ((WIDTH'(1) << i) - WIDTH'(1))) == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            Q     <= '0;
            tc    <= 1'b0;
        end else begin
            state <= next_state;
            Q     <= next_q;
            tc    <= next_tc;
        end
    end

    // Load wins over enable; decrement only happens while running, so Q saturates at 0 in IDLE.
    always_comb begin
        next_state = state;
        next_q     = Q;
        next_tc    = 1'b0;
        if (load) begin
            next_q     = load_val;
            next_state = (load_val != '0) ? RUN : IDLE;
        end else if (state == RUN && en) begin
            if (Q == WIDTH'(1)) begin
                next_tc    = 1'b1;
                next_q     = restart_val;
                next_state = AUTO_RELOAD ? RUN : IDLE;
            end else begin
                next_q = Q ^ toggle;
            end
        end
    end

    always_comb begin
        busy = (state == RUN);
        zero = (Q == '0);
    end

endmodule
